// File: rtl/enigma_symb_feeder.sv
// ASCII-to-Enigma symbol feeder: filters letters, queues them and issues
// one-cycle symbol pulses separated by GAP idle cycles for the enigma_1 core.
module enigma_symb_feeder #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP        = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    ascii_i,
  input  logic                          ascii_valid_i,
  output logic                          ascii_ready_o,
  output logic [5:0]                    symb_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [7:0]                    drop_cnt_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e          state_q, state_d;
  logic [5:0]      symb_q, symb_d;
  logic [3:0]      gap_q, gap_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      drop_q, drop_d;
  logic [5:0]      mem_q [FIFO_DEPTH];

  logic is_letter, accept, push, pop, empty, full;
  logic [5:0] code;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(FIFO_DEPTH));

  // Both cases map to their alphabet position via the low five bits.
  assign is_letter = ((ascii_i >= 8'h41) && (ascii_i <= 8'h5A)) ||
                     ((ascii_i >= 8'h61) && (ascii_i <= 8'h7A));
  assign code      = {1'b0, ascii_i[4:0]};
  assign accept    = ascii_valid_i && !full;
  assign push      = accept && is_letter;

  always_comb begin
    state_d = state_q;
    symb_d  = 6'd0;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          symb_d  = mem_q[rd_ptr_q];
          state_d = SEND;
        end
      end
      SEND: begin
        gap_d   = 4'(GAP - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (!empty) begin
          pop     = 1'b1;
          symb_d  = mem_q[rd_ptr_q];
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    drop_d   = drop_q;
    if (accept && !is_letter && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      symb_q   <= 6'd0;
      gap_q    <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      symb_q   <= symb_d;
      gap_q    <= gap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= code;
  end

  assign ascii_ready_o = !full;
  assign symb_o        = symb_q;
  assign fifo_level_o  = level_q;
  assign drop_cnt_o    = drop_q;
  assign busy_o        = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_enigma_symb_feeder.sv
// Directed bench for enigma_symb_feeder: reset, latency, burst cadence,
// back-pressure, filtering/saturation and mid-operation reset.
module tb_enigma_symb_feeder;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ascii;
  logic       valid;
  logic       ready;
  logic [5:0] symb;
  logic [3:0] level;
  logic [7:0] drop;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int sv_q[$];
  int sc_q[$];

  enigma_symb_feeder #(.FIFO_DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .ascii_i(ascii), .ascii_valid_i(valid),
    .ascii_ready_o(ready), .symb_o(symb), .fifo_level_o(level),
    .drop_cnt_o(drop), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every non-zero symbol cycle with the edge number that loaded it.
  always @(negedge clk) begin
    if (symb != 6'd0) begin
      sv_q.push_back(int'(symb));
      sc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] c);
    ascii = c;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic wait_syms(input int n, input int budget, input string tag);
    int g = 0;
    while (sv_q.size() < n && g < budget) begin
      step();
      g++;
    end
    chk({tag, "_count"}, sv_q.size(), n);
  endtask

  task automatic clr_q();
    sv_q.delete();
    sc_q.delete();
  endtask

  initial begin
    int k;
    int exp_hello[5];
    int maxlvl;
    int acc;
    int guard;

    rst = 1'b1; valid = 1'b1; ascii = 8'h41;
    step(2);
    rst = 1'b0; valid = 1'b0;
    chk("rst_symb", symb, 0);
    chk("rst_ready", ready, 1);
    chk("rst_level", level, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    step(10);
    chk("rst_no_sym", sv_q.size(), 0);
    chk("rst_level_late", level, 0);

    // Single letter: 'C' -> 3, two-edge latency, one cycle wide
    clr_q();
    send(8'h43);
    k = cyc;
    step(GAP + 1);
    chk("single_busy_hi", busy, 1);
    step();
    chk("single_busy_lo", busy, 0);
    chk("single_count", sv_q.size(), 1);
    if (sv_q.size() >= 1) begin
      chk("single_val", sv_q[0], 3);
      chk("single_lat", sc_q[0], k + 1);
    end

    // Burst "HeLLo": 8,5,12,12,15 every GAP+1 cycles
    clr_q();
    exp_hello = '{8, 5, 12, 12, 15};
    send("H"); send("e"); send("L"); send("L"); send("o");
    wait_syms(5, 100, "hello");
    for (int i = 0; i < 5 && i < sv_q.size(); i++) begin
      chk($sformatf("hello_val%0d", i), sv_q[i], exp_hello[i]);
      if (i > 0) chk($sformatf("hello_gap%0d", i), sc_q[i] - sc_q[i-1], GAP + 1);
    end
    step(10);
    chk("hello_no_extra", sv_q.size(), 5);

    // Full FIFO: A..L offered continuously
    clr_q();
    maxlvl = 0;
    for (int i = 0; i < 12; i++) begin
      ascii = 8'h41 + 8'(i);
      valid = 1'b1;
      guard = 0;
      do begin
        acc = ready;
        if (int'(level) > maxlvl) maxlvl = int'(level);
        chk("full_rdy_vs_lvl", ready, (level != 4'(DEPTH)));
        step();
        guard++;
      end while (!acc && guard < 100);
      if (!acc) chk("full_accept_timeout", 0, 1);
    end
    valid = 1'b0;
    chk("full_maxlvl", maxlvl, DEPTH);
    wait_syms(12, 200, "full");
    for (int i = 0; i < 12 && i < sv_q.size(); i++)
      chk($sformatf("full_val%0d", i), sv_q[i], i + 1);
    step(10);
    chk("full_no_extra", sv_q.size(), 12);
    chk("full_idle", busy, 0);

    // Filtering: boundary non-letters, then saturation
    clr_q();
    send(8'h31); send(8'h20); send(8'h40); send(8'h5B); send(8'h60); send(8'h7B);
    step(10);
    chk("filt_drop6", drop, 6);
    chk("filt_no_sym", sv_q.size(), 0);
    chk("filt_level", level, 0);
    for (int i = 0; i < 300; i++) send(8'h30 + 8'(i % 10));
    chk("filt_sat", drop, 255);
    chk("filt_no_sym2", sv_q.size(), 0);

    // Reset while in WAIT with three symbols queued
    send("A"); send("B"); send("C"); send("D");
    chk("mid_level3", level, 3);
    chk("mid_symb0", symb, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clr_q();
    chk("mid_symb", symb, 0);
    chk("mid_level", level, 0);
    chk("mid_drop", drop, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", ready, 1);
    step(30);
    chk("mid_no_sym", sv_q.size(), 0);
    send("Z");
    k = cyc;
    step(3);
    chk("z_count", sv_q.size(), 1);
    if (sv_q.size() >= 1) begin
      chk("z_val", sv_q[0], 26);
      chk("z_lat", sc_q[0], k + 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
